// File: rtl/watch_time_ctrl.sv
// Time-of-day controller: owns hours/minutes/seconds, advances them from a
// 1 Hz prescaler tick while running and applies arbitrated, auto-repeating
// manual adjust steps while in set mode.
// Optional build macro WATCH_TWELVE_HOUR_EN: hours output in 1..12 format
// plus a registered pm flag; internal counting stays 0..23.
module watch_time_ctrl #(
  parameter int CLK_HZ        = 32768,
  parameter int REPEAT_DELAY  = 16384,
  parameter int REPEAT_PERIOD = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_time,
  input  logic       inc_m,
  input  logic       dec_m,
  input  logic       inc_h,
  input  logic       dec_h,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
`ifdef WATCH_TWELVE_HOUR_EN
  output logic       pm,
`endif
  output logic       tick_1hz
);

  localparam int PS_W  = $clog2(CLK_HZ) + 1;
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(RMAX) + 1;
  localparam logic [PS_W-1:0]  PS_TOP = PS_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LD = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} adj_state_t;
  typedef enum logic [1:0] {REQ_INC_M, REQ_DEC_M, REQ_INC_H, REQ_DEC_H} req_t;

  adj_state_t       state, state_nx;
  req_t             code, code_nx, req_code;
  logic             req_valid, step;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [PS_W-1:0]  ps, ps_nx;
  logic [4:0]       hr, hr_nx;
  logic [5:0]       min_nx, sec_nx;
  logic             tick_nx;

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_mod60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec_mod24(input logic [4:0] v);
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

`ifdef WATCH_TWELVE_HOUR_EN
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    if (h == 5'd0)      return 5'd12;
    else if (h > 5'd12) return h - 5'd12;
    else                return h;
  endfunction
`endif

  // Decode the request lines: valid only when exactly one is asserted
  always_comb begin
    req_valid = 1'b0;
    req_code  = REQ_INC_M;
    case ({dec_h, inc_h, dec_m, inc_m})
      4'b0001: begin req_valid = 1'b1; req_code = REQ_INC_M; end
      4'b0010: begin req_valid = 1'b1; req_code = REQ_DEC_M; end
      4'b0100: begin req_valid = 1'b1; req_code = REQ_INC_H; end
      4'b1000: begin req_valid = 1'b1; req_code = REQ_DEC_H; end
      default: begin req_valid = 1'b0; req_code = REQ_INC_M; end
    endcase
  end

  // Adjust FSM state, latched request code and repeat counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      code  <= REQ_INC_M;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      code  <= code_nx;
      cnt   <= cnt_nx;
    end
  end

  // Adjust FSM next state: first press steps at once, then delay, then repeat
  always_comb begin
    state_nx = state;
    code_nx  = code;
    cnt_nx   = cnt;
    step     = 1'b0;
    if (run_time || !req_valid) begin
      state_nx = IDLE;
    end else if (state == IDLE || req_code != code) begin
      step     = 1'b1;
      code_nx  = req_code;
      cnt_nx   = DLY_LD;
      state_nx = DELAY;
    end else if (cnt == '0) begin
      step     = 1'b1;
      cnt_nx   = RPT_LD;
      state_nx = REPEAT;
    end else begin
      cnt_nx = cnt - 1'b1;
    end
  end

  // Time datapath next values: tick arithmetic when running, steps otherwise
  always_comb begin
    hr_nx   = hr;
    min_nx  = minutes;
    sec_nx  = seconds;
    ps_nx   = ps;
    tick_nx = 1'b0;
    if (run_time) begin
      if (ps == PS_TOP) begin
        ps_nx   = '0;
        tick_nx = 1'b1;
        sec_nx  = inc_mod60(seconds);
        if (seconds == 6'd59) begin
          min_nx = inc_mod60(minutes);
          if (minutes == 6'd59) hr_nx = inc_mod24(hr);
        end
      end else begin
        ps_nx = ps + 1'b1;
      end
    end else begin
      ps_nx = '0;
      if (step) begin
        case (req_code)
          REQ_INC_M: begin min_nx = inc_mod60(minutes); sec_nx = 6'd0; end
          REQ_DEC_M: begin min_nx = dec_mod60(minutes); sec_nx = 6'd0; end
          REQ_INC_H: hr_nx = inc_mod24(hr);
          REQ_DEC_H: hr_nx = dec_mod24(hr);
          default:   hr_nx = hr;
        endcase
      end
    end
  end

  // Time registers and registered display outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      hr       <= 5'd0;
      minutes  <= 6'd0;
      seconds  <= 6'd0;
      ps       <= '0;
      tick_1hz <= 1'b0;
`ifdef WATCH_TWELVE_HOUR_EN
      hours    <= 5'd12;
      pm       <= 1'b0;
`else
      hours    <= 5'd0;
`endif
    end else begin
      hr       <= hr_nx;
      minutes  <= min_nx;
      seconds  <= sec_nx;
      ps       <= ps_nx;
      tick_1hz <= tick_nx;
`ifdef WATCH_TWELVE_HOUR_EN
      hours    <= to_12h(hr_nx);
      pm       <= (hr_nx >= 5'd12);
`else
      hours    <= hr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Self-checking bench for watch_time_ctrl with small timing parameters.
// Reference model keeps time as plain integers and models auto-repeat by
// counting how long the same request has been held.
module tb_watch_time_ctrl;

  localparam int CLK_HZ = 4;
  localparam int RD     = 8;
  localparam int RP     = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run_time = 1'b0;
  logic inc_m = 1'b0, dec_m = 1'b0, inc_h = 1'b0, dec_h = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic tick_1hz;
  logic pm_bit;
  logic [18:0] obs;

`ifdef WATCH_TWELVE_HOUR_EN
  logic pm;
  assign pm_bit = pm;
`else
  assign pm_bit = 1'b0;
`endif
  assign obs = {hours, minutes, seconds, tick_1hz, pm_bit};

  watch_time_ctrl #(
    .CLK_HZ(CLK_HZ), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .run_time(run_time),
    .inc_m(inc_m), .dec_m(dec_m), .inc_h(inc_h), .dec_h(dec_h),
    .hours(hours), .minutes(minutes), .seconds(seconds),
`ifdef WATCH_TWELVE_HOUR_EN
    .pm(pm),
`endif
    .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: internal hour/minute/second, prescaler phase, held request
  int mh = 0, mm = 0, ms = 0, mps = 0, mtick = 0, mcode = -1, mhold = 0;

  function automatic int req_of();
    int n;
    int r;
    n = 0;
    r = -1;
    if (inc_m) begin n++; r = 0; end
    if (dec_m) begin n++; r = 1; end
    if (inc_h) begin n++; r = 2; end
    if (dec_h) begin n++; r = 3; end
    return (n == 1) ? r : -1;
  endfunction

  function automatic int hdisp(input int h);
`ifdef WATCH_TWELVE_HOUR_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
`endif
    return h;
  endfunction

  function automatic logic [18:0] exp_vec();
    logic p;
`ifdef WATCH_TWELVE_HOUR_EN
    p = (mh >= 12);
`else
    p = 1'b0;
`endif
    return {5'(hdisp(mh)), 6'(mm), 6'(ms), 1'(mtick), p};
  endfunction

  task automatic model_edge();
    int r;
    int t;
    if (!reset) begin
      mh = 0; mm = 0; ms = 0; mps = 0; mtick = 0; mcode = -1; mhold = 0;
      return;
    end
    r = req_of();
    mtick = 0;
    if (run_time) begin
      mcode = -1;
      mps++;
      if (mps == CLK_HZ) begin
        mps = 0;
        mtick = 1;
        t = (mh * 3600 + mm * 60 + ms + 1) % 86400;
        mh = t / 3600;
        mm = (t / 60) % 60;
        ms = t % 60;
      end
    end else begin
      mps = 0;
      if (r < 0) begin
        mcode = -1;
      end else begin
        if (r == mcode) mhold++;
        else begin mcode = r; mhold = 0; end
        if (mhold == 0 || (mhold >= RD && (mhold - RD) % RP == 0)) begin
          case (r)
            0: begin mm = (mm + 1) % 60; ms = 0; end
            1: begin mm = (mm + 59) % 60; ms = 0; end
            2: mh = (mh + 1) % 24;
            default: mh = (mh + 23) % 24;
          endcase
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic rn, input logic rt, input logic [3:0] req);
    reset = rn;
    run_time = rt;
    {dec_h, inc_h, dec_m, inc_m} = req;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'b0100);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      checks++;
      if ({hours, minutes, seconds, tick_1hz} !== {5'(hdisp(0)), 6'd0, 6'd0, 1'b0}) begin
        failures++;
        $display("FAIL reset_zero cyc=%0d got=%0d:%0d:%0d t=%0b", i, hours, minutes, seconds, tick_1hz);
      end
    end
    drive(1'b1, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_rollover();
    logic [3:0] seq [4];
    int ticks;
    int first_tick;
    int last_tick;
    seq[0] = 4'b1000; seq[1] = 4'b0000; seq[2] = 4'b0010; seq[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, seq[i]);
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL preload_adj cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    drive(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 58 * CLK_HZ; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL preload_run cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({hours, minutes, seconds} !== {5'(hdisp(23)), 6'd59, 6'd58}) begin
      failures++;
      $display("FAIL preload_value got=%0d:%0d:%0d exp=23:59:58", hours, minutes, seconds);
    end
    ticks = 0; first_tick = -1; last_tick = -1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL rollover cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (tick_1hz === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
        last_tick = i;
      end
    end
    checks++;
    if (ticks != 2 || last_tick - first_tick != 4) begin
      failures++;
      $display("FAIL rollover_ticks got=%0d gap=%0d exp=2 gap=4", ticks, last_tick - first_tick);
    end
    checks++;
    if ({hours, minutes, seconds} !== {5'(hdisp(0)), 6'd0, 6'd0}) begin
      failures++;
      $display("FAIL rollover_final got=%0d:%0d:%0d exp=00:00:00", hours, minutes, seconds);
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] seq [5];
    int chg [$];
    logic [5:0] prev;
    seq[0] = 4'b0000; seq[1] = 4'b0010; seq[2] = 4'b0000; seq[3] = 4'b0010; seq[4] = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, seq[i]);
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL repeat_setup cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (minutes !== 6'd58) begin
      failures++;
      $display("FAIL repeat_start got=%0d exp=58", minutes);
    end
    drive(1'b1, 1'b0, 4'b0001);
    prev = minutes;
    for (int i = 1; i <= 13; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL auto_repeat cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (minutes !== prev) chg.push_back(i);
      prev = minutes;
    end
    checks++;
    if (chg.size() != 4 || chg[0] != 1 || chg[1] != 9 || chg[2] != 11 || chg[3] != 13) begin
      failures++;
      $display("FAIL repeat_timing got=%0d changes exp=4 at 1,9,11,13", chg.size());
    end
    checks++;
    if ({hours, minutes, seconds} !== {5'(hdisp(0)), 6'd2, 6'd0}) begin
      failures++;
      $display("FAIL repeat_final got=%0d:%0d:%0d exp=00:02:00", hours, minutes, seconds);
    end
  endtask

  task automatic test_conflict_swap();
    logic [5:0] m0;
    logic [4:0] h0;
    int chg [$];
    logic [4:0] prev;
    drive(1'b1, 1'b0, 4'b0000);
    cycle();
    m0 = minutes;
    h0 = hours;
    drive(1'b1, 1'b0, 4'b1001);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec() || minutes !== m0 || hours !== h0) begin
        failures++;
        $display("FAIL conflict cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    drive(1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL swap_hold cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    drive(1'b1, 1'b0, 4'b1000);
    prev = hours;
    for (int i = 1; i <= 11; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL swap cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (hours !== prev) chg.push_back(i);
      prev = hours;
    end
    checks++;
    if (chg.size() != 3 || chg[0] != 1 || chg[1] != 9 || chg[2] != 11) begin
      failures++;
      $display("FAIL swap_timing got=%0d changes exp=3 at 1,9,11", chg.size());
    end
  endtask

  task automatic test_run_gating();
    logic [5:0] m0;
    drive(1'b1, 1'b0, 4'b0000);
    cycle();
    m0 = minutes;
    drive(1'b1, 1'b1, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (obs !== exp_vec() || minutes !== m0) begin
        failures++;
        $display("FAIL run_gate cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    drive(1'b1, 1'b0, 4'b0010);
    cycle();
    checks++;
    if (minutes !== 6'((int'(m0) + 59) % 60) || seconds !== 6'd0 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL run_release got=%0d exp=%0d", minutes, (int'(m0) + 59) % 60);
    end
  endtask

`ifdef WATCH_TWELVE_HOUR_EN
  task automatic test_twelve_hour();
    drive(1'b0, 1'b0, 4'b0000);
    cycle();
    drive(1'b1, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (hours !== 5'd12 || pm !== 1'b0) begin
      failures++;
      $display("FAIL h12_midnight got=%0d pm=%0b exp=12 pm=0", hours, pm);
    end
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b0, 4'b1000);
      cycle();
      drive(1'b1, 1'b0, 4'b0000);
      cycle();
    end
    checks++;
    if (hours !== 5'd1 || pm !== 1'b1) begin
      failures++;
      $display("FAIL h12_thirteen got=%0d pm=%0b exp=1 pm=1", hours, pm);
    end
    drive(1'b1, 1'b0, 4'b1000);
    cycle();
    drive(1'b1, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (hours !== 5'd12 || pm !== 1'b1 || obs !== exp_vec()) begin
      failures++;
      $display("FAIL h12_noon got=%0d pm=%0b exp=12 pm=1", hours, pm);
    end
  endtask
`endif

  task automatic test_random();
    int hold;
    int sel;
    logic rt;
    logic [3:0] req;
    hold = 0;
    rt = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 24);
        sel = $urandom_range(0, 7);
        case (sel)
          0: req = 4'b0001;
          1: req = 4'b0010;
          2: req = 4'b0100;
          3: req = 4'b1000;
          4: req = 4'b0101;
          5: req = 4'(1 << $urandom_range(0, 3));
          default: req = 4'b0000;
        endcase
        if ($urandom_range(0, 4) == 0) rt = ~rt;
      end
      hold--;
      drive(($urandom_range(0, 299) != 0), rt, req);
      cycle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_auto_repeat();
    test_conflict_swap();
    test_run_gating();
`ifdef WATCH_TWELVE_HOUR_EN
    test_twelve_hour();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_time_ctrl.md
Name: watch_time_ctrl

Overview:
- Time-of-day controller. Owns the hours/minutes/seconds registers and sequences every write to them.
- Sources of change: a 1 Hz tick from an internal prescaler while the watch runs, and manual adjust requests from the watch state FSM (run_time, inc_m, dec_m, inc_h, dec_h) while in set mode.
- Adjust requests are arbitrated, converted to single steps, and auto-repeated while held.
- Outputs feed the 7-segment display controller.

Parameters:
- CLK_HZ, 32768, clk cycles per second; prescaler terminal count is CLK_HZ-1.
- REPEAT_DELAY, 16384, cycles a request must be held after its first step before auto-repeat begins.
- REPEAT_PERIOD, 4096, cycles between auto-repeat steps.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- run_time  in  1  1 = timekeeping runs; 0 = set mode, adjusts honoured.
- inc_m  in  1  level request: minute +1.
- dec_m  in  1  level request: minute -1.
- inc_h  in  1  level request: hour +1.
- dec_h  in  1  level request: hour -1.
- hours  out  5  hour count, 0..23, registered.
- minutes  out  6  minute count, 0..59, registered.
- seconds  out  6  second count, 0..59, registered.
- tick_1hz  out  1  one-cycle pulse on each seconds update.

Behaviour:
- Reset: on a rising clk edge with reset=0, all of the following are cleared and reset dominates all other activity:
  - hours=0, minutes=0, seconds=0, tick_1hz=0
  - prescaler=0
  - adjust FSM=IDLE, repeat counter=0
- Prescaler, run_time=1:
  - Increments by 1 each cycle.
  - At CLK_HZ-1 it wraps to 0 and tick_1hz=1 for that cycle's registered output. Exactly one pulse per CLK_HZ cycles.
- Prescaler, run_time=0: held at 0; tick_1hz=0.
- Tick arithmetic (on tick):
  - seconds+1, 59->0 with carry to minutes.
  - minutes 59->0 with carry to hours.
  - hours 23->0.
  - 23:59:59 -> 00:00:00 in one cycle.
- Adjusts are ignored while run_time=1. Tick and adjust are therefore mutually exclusive; no collision case exists.
- Request decode, evaluated only while run_time=0:
  - req_valid = exactly one of {inc_m, dec_m, inc_h, dec_h} high.
  - Zero requests, or two or more simultaneously: no step, FSM -> IDLE.
- Adjust FSM states: IDLE, DELAY, REPEAT.
  - IDLE: if req_valid, apply one step, latch the request code, load counter=REPEAT_DELAY-1, go to DELAY.
  - DELAY: same request held -> decrement counter. At 0: apply step, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: same request held -> decrement counter. At 0: apply step, reload REPEAT_PERIOD-1.
  - DELAY/REPEAT, request released or invalid: go to IDLE, no step.
  - DELAY/REPEAT, a different single valid request: treated as a new press. Step applied same cycle, new code latched, DELAY reloaded.
  - run_time rising while not IDLE: FSM -> IDLE.
- Adjust arithmetic:
  - minutes wrap 59<->0 with no carry into hours.
  - hours wrap 23<->0.
  - Any applied minute step also clears seconds to 0 and prescaler to 0.
  - Hour steps leave seconds unchanged.
- Latency: a step is visible on the outputs the cycle after the request is first sampled high.
- Held request timing: steps occur at sample cycles 0, REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, +2*REPEAT_PERIOD, and so on.

Optional Feature:
- Macro: WATCH_TWELVE_HOUR_EN.
- Defined:
  - hours output is 12-hour format, 1..12 (internal 0 -> 12, 13..23 -> 1..11).
  - Extra output port pm (1 bit, registered) = 1 when internal hour >= 12.
  - Internal counting and adjust wrap are unchanged.
- Undefined: hours output is 0..23 and the pm port does not exist.

Test Plan (sim parameters CLK_HZ=4, REPEAT_DELAY=8, REPEAT_PERIOD=2):
- Reset: hold reset=0 for 2 cycles with inc_h=1 -> hours=0, minutes=0, seconds=0, tick_1hz=0 throughout; no step applied.
- Rollover: preload 23:59:58 via adjusts, run_time=1 for 8 cycles -> exactly two tick_1hz pulses, 4 cycles apart; final 00:00:00.
- Auto-repeat: run_time=0, minutes=58, hold inc_m for 13 cycles -> minutes 59,0,1,2 at cycles 1,9,11,13; hours unchanged; seconds=0.
- Conflict and swap:
  - inc_m and dec_h high the same cycle -> no change.
  - Then switch to dec_h alone while in REPEAT -> hours decrements the next cycle and the repeat delay restarts.
- Run gating: run_time=1 with dec_m held -> minutes unchanged; after run_time falls the held dec_m steps immediately (one cycle later).
- Feature, WATCH_TWELVE_HOUR_EN defined:
  - Internal hour 0 -> hours=12, pm=0.
  - Internal hour 13 -> hours=1, pm=1.
  - Internal hour 12 -> hours=12, pm=1.
